// File: rtl/ntt_multilane_sequencer.sv
// ============================================================================
// ntt_multilane_sequencer : ping-pong NTT/INTT address sequencer, LANES-wide.
// Optional feature macro: NTT_PERF_CNT_EN (busy-cycle counter on cycle_count)
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ntt_multilane_sequencer #(
    parameter int N          = 256,
    parameter int ADDR_WIDTH = $clog2(N),
    parameter int LANES      = 1,
    parameter int LATENCY    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          mode,
    output logic                          busy,
    output logic                          done,
    output logic                          res_bank,
    output logic                          err,
    output logic                          rd_bank,
    output logic                          rd_en,
    output logic [LANES*ADDR_WIDTH-1:0]   rd_addr_a,
    output logic [LANES*ADDR_WIDTH-1:0]   rd_addr_b,
    output logic [LANES*ADDR_WIDTH-1:0]   tw_addr,
    output logic                          bf_valid_in,
    output logic                          bf_inverse,
    input  logic                          bf_valid_out,
    output logic                          wr_bank,
    output logic                          wr_en,
    output logic [LANES*ADDR_WIDTH-1:0]   wr_addr_a,
    output logic [LANES*ADDR_WIDTH-1:0]   wr_addr_b,
    output logic [31:0]                   cycle_count
);

    localparam int   LOG2N    = $clog2(N);
    localparam int   ISSUES   = N / (2 * LANES);
    localparam int   IW       = (ISSUES > 1) ? $clog2(ISSUES) : 1;
    localparam int   SW       = $clog2(LOG2N);
    localparam int   DW       = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int   DEPTH    = 1 + LATENCY;
    localparam int   VW       = LANES * ADDR_WIDTH;
    localparam logic RES_BANK = ((LOG2N % 2) == 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   issue_cnt;
    logic [SW-1:0]   stage;
    logic [DW-1:0]   drain_cnt;
    logic            mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            issue_cnt <= '0;
            stage     <= '0;
            drain_cnt <= '0;
            mode_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_bank   <= 1'b0;
            res_bank  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_ISSUE;
                        mode_q    <= mode;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_bank   <= 1'b0;
                        stage     <= '0;
                        issue_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    if (issue_cnt == IW'(ISSUES - 1)) begin
                        state     <= S_DRAIN;
                        rd_en     <= 1'b0;
                        issue_cnt <= '0;
                        drain_cnt <= '0;
                    end else begin
                        issue_cnt <= issue_cnt + IW'(1);
                    end
                end
                S_DRAIN: begin
                    // Hold off the next stage until the last write of this one has landed
                    if (drain_cnt == DW'(LATENCY)) begin
                        if (stage == SW'(LOG2N - 1)) begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            res_bank <= RES_BANK;
                        end else begin
                            state   <= S_ISSUE;
                            stage   <= stage + SW'(1);
                            rd_bank <= ~rd_bank;
                            rd_en   <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [VW-1:0] a_vec, b_vec, tw_vec;
    logic [31:0]   j, lg, grp, k, a, b, tw, s32;

    always_comb begin
        a_vec  = '0;
        b_vec  = '0;
        tw_vec = '0;
        j = '0; lg = '0; grp = '0; k = '0; a = '0; b = '0; tw = '0;
        s32 = 32'(stage);
        for (int l = 0; l < LANES; l++) begin
            j   = 32'(issue_cnt) * 32'(LANES) + 32'(l);
            // NTT halves the span each stage, INTT doubles it
            lg  = mode_q ? s32 : (32'(LOG2N - 1) - s32);
            grp = j >> lg;
            k   = j & ((32'd1 << lg) - 32'd1);
            a   = (grp << (lg + 32'd1)) | k;
            b   = a + (32'd1 << lg);
            tw  = mode_q ? ((32'(N) >> s32) - 32'd1 - grp) : ((32'd1 << s32) + grp);
            a_vec[l*ADDR_WIDTH +: ADDR_WIDTH]  = a[ADDR_WIDTH-1:0];
            b_vec[l*ADDR_WIDTH +: ADDR_WIDTH]  = b[ADDR_WIDTH-1:0];
            tw_vec[l*ADDR_WIDTH +: ADDR_WIDTH] = tw[ADDR_WIDTH-1:0];
        end
    end

    assign rd_addr_a  = rd_en ? a_vec  : '0;
    assign rd_addr_b  = rd_en ? b_vec  : '0;
    assign tw_addr    = rd_en ? tw_vec : '0;
    assign bf_inverse = mode_q;

    logic [DEPTH-1:0] vld_pipe;
    logic [DEPTH-1:0] bank_pipe;
    logic [VW-1:0]    wa_pipe [DEPTH];
    logic [VW-1:0]    wb_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            bank_pipe <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                wa_pipe[i] <= '0;
                wb_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0]  <= rd_en;
            bank_pipe[0] <= rd_en & ~rd_bank;
            wa_pipe[0]   <= rd_addr_a;
            wb_pipe[0]   <= rd_addr_b;
            for (int i = 1; i < DEPTH; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                bank_pipe[i] <= bank_pipe[i-1];
                wa_pipe[i]   <= wa_pipe[i-1];
                wb_pipe[i]   <= wb_pipe[i-1];
            end
        end
    end

    assign bf_valid_in = vld_pipe[0];
    assign wr_en       = vld_pipe[DEPTH-1];
    assign wr_bank     = bank_pipe[DEPTH-1];
    assign wr_addr_a   = wa_pipe[DEPTH-1];
    assign wr_addr_b   = wb_pipe[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            err <= 1'b0;
        end else if (bf_valid_out != vld_pipe[DEPTH-1]) begin
            err <= 1'b1;
        end
    end

`ifdef NTT_PERF_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state == S_IDLE && start) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cycle_count = cnt_q;
`else
    assign cycle_count = '0;
`endif

endmodule

`default_nettype wire
